// File: rtl/sw_led_select_multi_pkg.sv
// sw_led_select_multi_pkg
//   Shared helpers for the multi-channel push-switch mode selector:
//   - clog2     : ceiling log2 used for counter / register widths
//   - maj3      : 3-input majority vote used by the debouncer
//   - DEF_*     : default parameter values for the top level
package sw_led_select_multi_pkg;

  localparam int DEF_NUM_SW     = 4;
  localparam int DEF_TICK_DIV   = 524288;
  localparam int DEF_NUM_MODES  = 4;
  localparam int DEF_LONG_TICKS = 64;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // True when at least two of the three samples are set.
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/sw_led_select_multi_debounce.sv
// sw_debounce_ch
//   One switch channel: 2-FF synchroniser, 3-sample shift register loaded
//   on the shared tick, majority filter, registered filtered level, edge
//   detection and a saturating hold counter.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_tick         shared sample tick (1-cycle pulse)
//   i_psw          raw asynchronous switch input
//   o_filt         registered debounced level
//   o_rise/o_fall  combinational edges of the debounced level
//   o_hold_done    high in the cycle the hold counter steps to LONG_TICKS
//   o_hold_lt      hold counter (before any clear) is below LONG_TICKS
module sw_debounce_ch
  import sw_led_select_multi_pkg::*;
#(
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_psw,
  output logic o_filt,
  output logic o_rise,
  output logic o_fall,
  output logic o_hold_done,
  output logic o_hold_lt
);

  localparam int HW = clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

  logic [1:0]    r_sync;
  logic [2:0]    r_smp;
  logic          r_filt;
  logic [HW-1:0] r_hold;
  logic          w_filt;
  logic          w_hold_inc;

  assign w_filt     = maj3(r_smp);
  assign w_hold_inc = i_tick & w_filt & (r_hold < HOLD_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_smp  <= '0;
      r_filt <= 1'b0;
      r_hold <= '0;
    end else begin
      r_sync <= {r_sync[0], i_psw};
      if (i_tick) r_smp <= {r_smp[1:0], r_sync[1]};
      r_filt <= w_filt;
      // Clearing on a low filter wins; otherwise count ticks up to saturation.
      if (!w_filt)         r_hold <= '0;
      else if (w_hold_inc) r_hold <= r_hold + 1'b1;
    end
  end

  assign o_filt      = r_filt;
  assign o_rise      = w_filt & ~r_filt;
  assign o_fall      = ~w_filt & r_filt;
  // Only the step into saturation fires, so a long hold reports once.
  assign o_hold_done = w_hold_inc & (r_hold == HOLD_LAST);
  // r_hold still holds its pre-clear value in the fall cycle.
  assign o_hold_lt   = (r_hold < HOLD_MAX);

endmodule

// File: rtl/sw_led_select_multi.sv
// sw_led_select_multi
//   NUM_SW independent push-switch channels. Each is debounced on a shared
//   slow tick and drives a wrap-around mode counter: a short press steps
//   the mode, a long press returns it to mode 0. Modes are shown one-hot.
// Ports:
//   CLK          clock (rising edge)
//   RST          synchronous active-high reset
//   PSW          raw switch inputs, one per channel
//   LED          one-hot mode per channel, LED[i*NUM_MODES+m]
//   SW_FILT      registered debounced level per channel
//   SHORT_PRESS  1-cycle pulse when a short press is accepted
//   LONG_PRESS   1-cycle pulse when a long press is recognised
module sw_led_select_multi
  import sw_led_select_multi_pkg::*;
#(
  parameter int NUM_SW     = DEF_NUM_SW,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int NUM_MODES  = DEF_NUM_MODES,
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_SW-1:0]           PSW,
  output logic [NUM_SW*NUM_MODES-1:0] LED,
  output logic [NUM_SW-1:0]           SW_FILT,
  output logic [NUM_SW-1:0]           SHORT_PRESS,
  output logic [NUM_SW-1:0]           LONG_PRESS
);

  localparam int CW = clog2(TICK_DIV);
  localparam int MW = (clog2(NUM_MODES) < 1) ? 1 : clog2(NUM_MODES);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);

  logic [CW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (RST)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    logic                 w_filt;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_hold_done;
    logic                 w_hold_lt;
    logic                 w_short;
    logic [MW-1:0]        r_mode;
    logic                 r_short;
    logic                 r_long;
    logic [NUM_MODES-1:0] w_led;

    sw_debounce_ch #(
      .LONG_TICKS (LONG_TICKS)
    ) u_deb (
      .i_clk       (CLK),
      .i_rst       (RST),
      .i_tick      (w_tick),
      .i_psw       (PSW[i]),
      .o_filt      (w_filt),
      .o_rise      (w_rise),
      .o_fall      (w_fall),
      .o_hold_done (w_hold_done),
      .o_hold_lt   (w_hold_lt)
    );

    // Release after a long press is swallowed: no pulse, no mode step.
    assign w_short = w_fall & w_hold_lt;

    // hold_done needs filt high and a short press needs filt low, so the
    // two branches never compete in the same cycle.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_mode  <= '0;
        r_short <= 1'b0;
        r_long  <= 1'b0;
      end else begin
        r_short <= w_short;
        r_long  <= w_hold_done;
        if (w_hold_done)  r_mode <= '0;
        else if (w_short) r_mode <= (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
      end
    end

    always_comb begin
      w_led = '0;
      for (int m = 0; m < NUM_MODES; m++) begin
        w_led[m] = (r_mode == MW'(m));
      end
    end

    assign LED[i*NUM_MODES +: NUM_MODES] = w_led;
    assign SW_FILT[i]     = w_filt;
    assign SHORT_PRESS[i] = r_short;
    assign LONG_PRESS[i]  = r_long;

    logic w_unused;
    assign w_unused = w_rise;
  end

endmodule

// File: tb/tb_sw_led_select_multi.sv
module tb_sw_led_select_multi;

  localparam int NSW = 2;
  localparam int TDIV = 4;
  localparam int NM = 4;
  localparam int LT = 5;
  localparam int W = 2 * NSW + NSW * NM;

  logic              clk;
  logic              rst;
  logic [NSW-1:0]    psw;
  logic [NSW*NM-1:0] led;
  logic [NSW-1:0]    sw_filt;
  logic [NSW-1:0]    short_press;
  logic [NSW-1:0]    long_press;

  int n_tests;
  int n_fail;
  int mode_m [NSW];
  logic [NSW-1:0] saw_filt;
  logic [W-1:0] exp_q[$];

  sw_led_select_multi #(
    .NUM_SW     (NSW),
    .TICK_DIV   (TDIV),
    .NUM_MODES  (NM),
    .LONG_TICKS (LT)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .PSW         (psw),
    .LED         (led),
    .SW_FILT     (sw_filt),
    .SHORT_PRESS (short_press),
    .LONG_PRESS  (long_press)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NSW*NM-1:0] led_model();
    logic [NSW*NM-1:0] v;
    v = '0;
    for (int c = 0; c < NSW; c++) v[c*NM + mode_m[c]] = 1'b1;
    return v;
  endfunction

  // scoreboard: every pulse cycle is compared with the next expected entry
  always @(negedge clk) begin
    if (!rst) begin
      saw_filt = saw_filt | sw_filt;
      if ((short_press | long_press) != '0) begin
        if (exp_q.size() == 0)
          check_val("sb_unexpected", 32'({long_press, short_press, led}), 32'(0));
        else
          check_val("sb_pulse", 32'({long_press, short_press, led}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
  endtask

  task automatic push_exp(input logic [NSW-1:0] lng, input logic [NSW-1:0] sht);
    exp_q.push_back({lng, sht, led_model()});
  endtask

  // press channel ch for nticks tick windows, then release and let it settle
  task automatic press(input int ch, input int nticks);
    psw[ch] = 1'b1;
    cycles(nticks * TDIV);
    psw[ch] = 1'b0;
    cycles(5 * TDIV);
  endtask

  task automatic short_press_ch(input int ch);
    logic [NSW-1:0] s;
    mode_m[ch] = (mode_m[ch] + 1) % NM;
    s = '0;
    s[ch] = 1'b1;
    push_exp('0, s);
    press(ch, 3);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    psw = '0;
    saw_filt = '0;
    for (int c = 0; c < NSW; c++) mode_m[c] = 0;
    do_reset();

    // reset state and idle
    check_val("rst_led", 32'(led), 32'(8'b0001_0001));
    check_val("rst_filt", 32'(sw_filt), 32'(0));
    check_val("rst_short", 32'(short_press), 32'(0));
    check_val("rst_long", 32'(long_press), 32'(0));
    cycles(40);
    check_val("idle_led", 32'(led), 32'(8'b0001_0001));
    check_val("idle_filt_seen", 32'(saw_filt), 32'(0));

    // short press on channel 0
    saw_filt = '0;
    short_press_ch(0);
    check_val("short_filt_rose", 32'(saw_filt[0]), 32'(1));
    check_val("short_filt_fell", 32'(sw_filt), 32'(0));
    check_val("short_led", 32'(led), 32'(8'b0001_0010));
    check_val("short_pending", 32'(exp_q.size()), 32'(0));

    // single-tick glitch
    saw_filt = '0;
    press(0, 1);
    check_val("glitch_filt", 32'(saw_filt), 32'(0));
    check_val("glitch_led", 32'(led), 32'(led_model()));

    // four presses on channel 1 wrap the mode
    for (int k = 0; k < 4; k++) begin
      short_press_ch(1);
      check_val("wrap_led", 32'(led), 32'(led_model()));
    end
    check_val("wrap_led_final", 32'(led), 32'(8'b0001_0010));
    check_val("wrap_pending", 32'(exp_q.size()), 32'(0));

    // long press from mode 2 on channel 0
    short_press_ch(0);
    check_val("pre_long_led", 32'(led), 32'(8'b0001_0100));
    mode_m[0] = 0;
    push_exp(2'b01, '0);
    press(0, 10);
    check_val("long_led", 32'(led), 32'(8'b0001_0001));
    check_val("long_pending", 32'(exp_q.size()), 32'(0));

    // set non-zero modes, then reset while both switches are held
    short_press_ch(0);
    short_press_ch(0);
    short_press_ch(1);
    check_val("pre_rst_led", 32'(led), 32'(8'b0010_0100));
    psw = 2'b11;
    cycles(4 * TDIV);
    check_val("held_filt", 32'(sw_filt), 32'(2'b11));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NSW; c++) mode_m[c] = 0;
    check_val("midrst_led", 32'(led), 32'(8'b0001_0001));
    check_val("midrst_filt", 32'(sw_filt), 32'(0));
    check_val("midrst_pulses", 32'({long_press, short_press}), 32'(0));
    // filter needs two tick samples after sync refills: within 3 ticks
    cycles(3 * TDIV);
    check_val("rerise_filt", 32'(sw_filt), 32'(2'b11));
    mode_m[0] = 1;
    mode_m[1] = 1;
    push_exp('0, 2'b11);
    psw = 2'b00;
    cycles(5 * TDIV);
    check_val("simul_led", 32'(led), 32'(8'b0010_0010));
    check_val("simul_pending", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
